// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, reset address,
// the halt opcode and the fetch FSM state encoding.
package fetch_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT  = 10;
    localparam int unsigned INSTR_WIDTH_DEFAULT = 12;
    localparam logic [9:0]  RESET_PC_DEFAULT    = 10'h000;
    localparam logic [11:0] HALT_OPCODE         = 12'hFFF;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StFlush,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter register: load has priority over increment, otherwise hold.
// Increment wraps modulo 2^ADDR_WIDTH without any flag.
module program_counter
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] load_val_i,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic [ADDR_WIDTH-1:0] pc_d, pc_q;

    // Next PC: redirect, sequential advance, or hold.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    // PC state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: drives the memory address from the PC, pairs the registered
// memory data with the address it belongs to (inflight_pc) and hands it downstream.
// Branches take two bubbles (branch edge plus one FLUSH edge). Optional halt-on-opcode
// behaviour is enabled by defining FETCH_HALT_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int unsigned           INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   reset_fetch,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  instruction_addr_pc,
    output logic [INSTR_WIDTH-1:0] fetched_instruction,
    output logic [ADDR_WIDTH-1:0]  fetched_pc,
    output logic                   fetch_valid,
    output logic                   halted
);

    fetch_state_e           state_d, state_q;
    logic [ADDR_WIDTH-1:0]  inflight_d, inflight_q;
    logic [INSTR_WIDTH-1:0] instr_d, instr_q;
    logic [ADDR_WIDTH-1:0]  fpc_d, fpc_q;
    logic                   valid_d, valid_q;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   pc_load, pc_inc;
    logic                   redirect;

    // Branches are ignored only in the single post-reset IDLE cycle.
    assign redirect = branch_taken && (state_q != StIdle);

    program_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_program_counter (
        .clk_i      (clk),
        .rst_i      (reset_fetch),
        .load_i     (pc_load),
        .load_val_i (branch_target),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    // Fetch FSM next state, PC control and output register next values.
    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q;
        instr_d    = instr_q;
        fpc_d      = fpc_q;
        valid_d    = valid_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        if (redirect) begin
            pc_load = 1'b1;
            valid_d = 1'b0;
            state_d = StFlush;
        end else if (!stall) begin
            case (state_q)
                StIdle, StFlush: begin
                    // Memory data on the input is not ours yet; just issue pc.
                    inflight_d = pc;
                    pc_inc     = 1'b1;
                    valid_d    = 1'b0;
                    state_d    = StFetch;
                end
                StFetch: begin
                    instr_d = instruction;
                    fpc_d   = inflight_q;
                    valid_d = 1'b1;
`ifdef FETCH_HALT_EN
                    if (instruction == INSTR_WIDTH'(HALT_OPCODE)) begin
                        // Present the halt opcode once, then freeze the PC.
                        state_d = StHalt;
                    end else begin
                        inflight_d = pc;
                        pc_inc     = 1'b1;
                    end
`else
                    inflight_d = pc;
                    pc_inc     = 1'b1;
`endif
                end
                StHalt: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset_fetch) begin
        if (reset_fetch) begin
            state_q    <= StIdle;
            inflight_q <= RESET_PC;
            instr_q    <= '0;
            fpc_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            instr_q    <= instr_d;
            fpc_q      <= fpc_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_HALT_EN
    logic halted_d, halted_q;

    // Halted rises on the first unstalled edge spent in HALT; a branch clears it.
    always_comb begin
        halted_d = halted_q;
        if (redirect) begin
            halted_d = 1'b0;
        end else if (!stall && (state_q == StHalt)) begin
            halted_d = 1'b1;
        end
    end

    // Halted flag register.
    always_ff @(posedge clk or posedge reset_fetch) begin
        if (reset_fetch) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign instruction_addr_pc = pc;
    assign fetched_instruction = instr_q;
    assign fetched_pc          = fpc_q;
    assign fetch_valid         = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. The reference model describes the fetch
// stream abstractly: a next-output address, a count of bubble edges still owed, and
// (with FETCH_HALT_EN) a halted flag. Memory stalls its read together with the fetcher.
module tb_instruction_fetch;

    localparam int unsigned AW = 10;
    localparam int unsigned IW = 12;
    localparam logic [AW-1:0] RST_PC = 10'h000;

    logic          clk = 1'b0;
    logic          reset_fetch;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic [IW-1:0] instruction;
    logic [AW-1:0] instruction_addr_pc;
    logic [IW-1:0] fetched_instruction;
    logic [AW-1:0] fetched_pc;
    logic          fetch_valid;
    logic          halted;

    instruction_fetch dut (
        .clk                 (clk),
        .reset_fetch         (reset_fetch),
        .stall               (stall),
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .instruction         (instruction),
        .instruction_addr_pc (instruction_addr_pc),
        .fetched_instruction (fetched_instruction),
        .fetched_pc          (fetched_pc),
        .fetch_valid         (fetch_valid),
        .halted              (halted)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] mem [0:(1<<AW)-1];

    // Registered-read instruction memory.
    always_ff @(posedge clk) begin
        if (!stall) instruction <= mem[instruction_addr_pc];
    end

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [AW-1:0] m_next;
    int            m_gap;
    bit            m_fresh;
    bit            m_fv;
    logic [AW-1:0] m_fpc;
    logic [IW-1:0] m_fi;
    bit            m_halt;
    bit            m_halted;

    task automatic model_reset();
        m_next   = RST_PC;
        m_gap    = 1;
        m_fresh  = 1'b1;
        m_fv     = 1'b0;
        m_fpc    = '0;
        m_fi     = '0;
        m_halt   = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit b, input logic [AW-1:0] t);
        if (b && !m_fresh) begin
            m_next   = t;
            m_gap    = 1;
            m_fv     = 1'b0;
            m_halt   = 1'b0;
            m_halted = 1'b0;
        end else if (!s) begin
            m_fresh = 1'b0;
            if (m_halt) begin
                m_fv     = 1'b0;
                m_halted = 1'b1;
            end else if (m_gap > 0) begin
                m_fv  = 1'b0;
                m_gap = m_gap - 1;
            end else begin
                m_fv   = 1'b1;
                m_fpc  = m_next;
                m_fi   = mem[m_next];
                m_next = m_next + AW'(1);
`ifdef FETCH_HALT_EN
                if (m_fi == 12'hFFF) m_halt = 1'b1;
`endif
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [AW-1:0] exp_addr;
        exp_addr = m_halt ? m_next : (m_gap == 0 ? m_next + AW'(1) : m_next);
        tests++;
        assert (fetch_valid === m_fv) else begin
            fails++;
            $error("FAIL %s fetch_valid observed=%0b expected=%0b", tag, fetch_valid, m_fv);
        end
        tests++;
        assert (instruction_addr_pc === exp_addr) else begin
            fails++;
            $error("FAIL %s addr observed=%h expected=%h", tag, instruction_addr_pc, exp_addr);
        end
        tests++;
        assert (halted === m_halted) else begin
            fails++;
            $error("FAIL %s halted observed=%0b expected=%0b", tag, halted, m_halted);
        end
        if (m_fv) begin
            tests++;
            assert (fetched_pc === m_fpc) else begin
                fails++;
                $error("FAIL %s fetched_pc observed=%h expected=%h", tag, fetched_pc, m_fpc);
            end
            tests++;
            assert (fetched_instruction === m_fi) else begin
                fails++;
                $error("FAIL %s instr observed=%h expected=%h", tag, fetched_instruction, m_fi);
            end
        end
    endtask

    task automatic step(input bit s, input bit b, input logic [AW-1:0] t, input string tag);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        @(posedge clk);
        model_edge(s, b, t);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        stall        = 1'b0;
        branch_taken = 1'b0;
        reset_fetch  = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        tests++;
        assert (fetched_pc === '0 && fetched_instruction === '0) else begin
            fails++;
            $error("FAIL %s outputs observed=%h/%h expected=0/0", tag, fetched_pc,
                   fetched_instruction);
        end
        reset_fetch = 1'b0;
        #2;
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = IW'(a) + 12'h100;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        reset_fetch   = 1'b0;
        do_reset("por");

        // Sequential fetch from reset, then a 3-cycle stall at fetched_pc=5.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, "seq");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, "stall");
        step(1'b0, 1'b0, '0, "resume");

        // Branch under stall has priority; two bubbles before target.
        step(1'b1, 1'b1, 10'h200, "br_stall");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, "br_target");

        // Back-to-back branch, then wrap across the top of the address space.
        step(1'b0, 1'b1, 10'h123, "br_first");
        step(1'b0, 1'b1, 10'h3FE, "br_again");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, "wrap");

        // Reset pulsed between edges while in FLUSH.
        step(1'b0, 1'b1, 10'h050, "br_flush");
        do_reset("rst_flush");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, "restart");

`ifdef FETCH_HALT_EN
        mem[4] = 12'hFFF;
        do_reset("rst_halt");
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, '0, "halt");
        step(1'b0, 1'b1, 10'h010, "halt_br");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, "halt_resume");
        mem[4] = 12'h104;
`endif

        // Randomized stalls, branches and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step($urandom_range(3) == 0, $urandom_range(9) == 0, AW'($urandom), "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, the instruction address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 12, the instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 10'h000, the first fetch address after reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port reset_fetch  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  high = hold all fetch state.
REQ-007 SHALL have port branch_taken  input  1  high = redirect fetch to branch_target.
REQ-008 SHALL have port branch_target  input  ADDR_WIDTH  redirect address.
REQ-009 SHALL have port instruction  input  INSTR_WIDTH  registered memory read data, valid one cycle after its address is presented.
REQ-010 SHALL have port instruction_addr_pc  output  ADDR_WIDTH  memory read address, driven directly from the PC register.
REQ-011 SHALL have port fetched_instruction  output  INSTR_WIDTH  instruction handed downstream.
REQ-012 SHALL have port fetched_pc  output  ADDR_WIDTH  address of fetched_instruction.
REQ-013 SHALL have port fetch_valid  output  1  fetched_instruction/fetched_pc are valid.
REQ-014 SHALL have port halted  output  1  high while in HALT.

Function
REQ-015 SHALL implement states IDLE, FETCH, FLUSH, HALT; internal registers pc and inflight_pc (address whose data is on instruction).
REQ-016 IDLE (entered only by reset) SHALL last one cycle: inflight_pc<=pc, pc<=pc+1, fetch_valid<=0, go to FETCH.
REQ-017 FETCH with stall=0, branch_taken=0 SHALL on each edge do: fetched_instruction<=instruction, fetched_pc<=inflight_pc, fetch_valid<=1, inflight_pc<=pc, pc<=pc+1.
REQ-018 pc increment SHALL wrap modulo 2^ADDR_WIDTH (10'h3FF -> 10'h000) with no flag.
REQ-019 stall=1 (branch_taken=0) SHALL hold pc, inflight_pc, state and all outputs unchanged.
REQ-020 branch_taken=1 in any state except IDLE SHALL have priority over stall: pc<=branch_target, fetch_valid<=0, halted<=0, go to FLUSH.
REQ-021 FLUSH SHALL discard the instruction input for one cycle, then: inflight_pc<=pc, pc<=pc+1, fetch_valid<=0, go to FETCH; first valid output is mem[branch_target] two edges after the branch edge.
REQ-022 Branch back-to-back (branch_taken high in FLUSH) SHALL restart FLUSH with the newest target.
REQ-023 Steady-state latency: address presented at edge n SHALL appear on fetched_instruction after edge n+2.

Reset
REQ-024 reset_fetch high SHALL immediately set pc=RESET_PC, inflight_pc=RESET_PC, state=IDLE, fetched_instruction=0, fetched_pc=0, fetch_valid=0, halted=0, regardless of clk.
REQ-025 Reset asserted mid-operation (any state, stall or branch pending) SHALL abandon the in-flight fetch; no stale instruction SHALL become valid afterwards.

Configuration
REQ-026 With macro FETCH_HALT_EN defined: in FETCH, capturing instruction 12'hFFF SHALL present it once with fetch_valid=1, then enter HALT (halted=1, fetch_valid=0, pc frozen); exit only via reset or branch_taken.
REQ-027 Without FETCH_HALT_EN: 12'hFFF SHALL be an ordinary instruction, HALT unreachable, halted tied to 0.

Structure
REQ-028 Package fetch_pkg SHALL hold ADDR_WIDTH/INSTR_WIDTH defaults, RESET_PC, HALT_OPCODE (12'hFFF) and the state enumeration.
REQ-029 One sub-module program_counter (pc register with load, increment-with-wrap, hold) SHALL be instantiated; the FSM and output registers stay in instruction_fetch.

Verification
REQ-030 Reset, release, memory mem[a]=a+12'h100 -> fetch_valid rises after edge 2; fetched_pc 0,1,2,3 with instructions 12'h100,12'h101,12'h102,12'h103.
REQ-031 stall high 3 cycles at fetched_pc=5 -> outputs and instruction_addr_pc frozen 3 cycles, then resume with fetched_pc=6.
REQ-032 branch_taken with target 10'h200 while stall=1 -> fetch_valid low 2 cycles, next valid fetched_pc=10'h200, instruction=mem[10'h200].
REQ-033 Start at pc 10'h3FE -> fetched_pc sequence 10'h3FE,10'h3FF,10'h000 with no gap.
REQ-034 FETCH_HALT_EN, mem[4]=12'hFFF -> fetched_pc=4 valid once, halted=1, instruction_addr_pc frozen; branch to 10'h010 clears halted and resumes.
REQ-035 reset_fetch pulsed between clock edges during FLUSH -> outputs zero immediately; sequence restarts at RESET_PC with no stale valid.
